// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII transmit speed adapter.
//   SPEED_10/100/1000 : speed encodings used on the speed / speed_active ports
//   tx_state_e        : nibble slot state for 10/100 (LOW nibble, then HIGH nibble)
//   norm_speed()      : folds the reserved code 11 onto 1000M
//   div_sel()         : TXC period in gmii_tx_clk cycles for a speed (1 for 1000M)
package rgmii_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } tx_state_e;

    function automatic logic [1:0] norm_speed(input logic [1:0] spd);
        return (spd == 2'b11) ? SPEED_1000 : spd;
    endfunction

    function automatic logic [31:0] div_sel(input logic [1:0]  spd,
                                            input logic [31:0] d10,
                                            input logic [31:0] d100);
        case (spd)
            SPEED_10:  return d10;
            SPEED_100: return d100;
            default:   return 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/rgmii_txc_phase.sv
// TXC phase generator for 10/100 Mb/s.
//   gmii_tx_clk, gmii_tx_rst_n : clock, async active-low reset
//   i_speed     : speed applied this cycle (selects the current TXC period)
//   i_speed_nx  : speed applied next cycle (for the look-ahead last flag)
//   i_restart   : force ph to 0 on this edge (speed (re)latched)
//   o_txc_d0/d1 : TXC bits for the rising/falling half of this cycle
//   o_last      : ph is at DIV-1 this cycle
//   o_last_nx   : ph will be at DIV-1 next cycle
module rgmii_txc_phase
    import rgmii_pkg::*;
#(
    parameter int unsigned DIV_100 = 5,
    parameter int unsigned DIV_10  = 50
) (
    input  logic       gmii_tx_clk,
    input  logic       gmii_tx_rst_n,
    input  logic [1:0] i_speed,
    input  logic [1:0] i_speed_nx,
    input  logic       i_restart,
    output logic       o_txc_d0,
    output logic       o_txc_d1,
    output logic       o_last,
    output logic       o_last_nx
);

    localparam int unsigned PW = $clog2(DIV_10);

    logic [PW-1:0] r_ph;
    logic [31:0]   w_ph;
    logic [31:0]   w_ph_nx;
    logic [31:0]   w_div;
    logic [31:0]   w_div_nx;

    always_comb begin
        w_div     = div_sel(i_speed, DIV_10, DIV_100);
        w_div_nx  = div_sel(i_speed_nx, DIV_10, DIV_100);
        w_ph      = 32'(r_ph);
        o_last    = (w_ph == w_div - 32'd1);
        // At 1000M the period is 1, so ph simply stays at 0.
        w_ph_nx   = (i_restart || o_last) ? 32'd0 : w_ph + 32'd1;
        o_last_nx = (w_ph_nx == w_div_nx - 32'd1);
        // Half-cycle resolution: an odd DIV puts the edge mid-cycle.
        o_txc_d0  = (32'd2 * w_ph) < w_div;
        o_txc_d1  = (32'd2 * w_ph + 32'd1) < w_div;
    end

    always_ff @(posedge gmii_tx_clk or negedge gmii_tx_rst_n) begin
        if (!gmii_tx_rst_n) r_ph <= '0;
        else                r_ph <= w_ph_nx[PW-1:0];
    end

endmodule

// File: rtl/rgmii_tx_speed_adapter.sv
// GMII -> RGMII transmit adapter feeding ODDRX1F primitives, 10/100/1000 Mb/s.
//   gmii_tx_clk, gmii_tx_rst_n   : 125 MHz clock, async active-low reset
//   speed                        : 00=10M 01=100M 10/11=1000M (latched at gaps)
//   gmii_tx_data/en/er           : byte, frame-active, error; taken when ready=1
//   gmii_tx_ready                : inputs are sampled on the edge where this is high
//   txd_d0/d1, ctl_d0/d1         : rising/falling-half data nibble and TX_CTL
//   txc_d0/d1                    : rising/falling-half TXC pattern
//   speed_active                 : speed currently applied
// A sampled byte reaches the DDR outputs one cycle after its sample edge.
module rgmii_tx_speed_adapter
    import rgmii_pkg::*;
#(
    parameter int unsigned DIV_100 = 5,
    parameter int unsigned DIV_10  = 50
) (
    input  logic       gmii_tx_clk,
    input  logic       gmii_tx_rst_n,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_tx_data,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    output logic       gmii_tx_ready,
    output logic [3:0] txd_d0,
    output logic [3:0] txd_d1,
    output logic       ctl_d0,
    output logic       ctl_d1,
    output logic       txc_d0,
    output logic       txc_d1,
    output logic [1:0] speed_active
);

    tx_state_e  r_state, w_state_nx;
    logic [1:0] r_speed, w_speed_nx;
    logic       r_first, r_ready, w_ready_nx;
    logic       w_sample, w_spd_upd;
    logic [7:0] r_data;
    logic       r_en, r_er;
    logic       w_txc0, w_txc1, w_last, w_last_nx;
    logic [3:0] w_nib, w_txd0, w_txd1, r_txd0, r_txd1;
    logic       w_ctl0, w_ctl1, w_tc0, w_tc1;
    logic       r_ctl0, r_ctl1, r_tc0, r_tc1;

    rgmii_txc_phase #(
        .DIV_100 (DIV_100),
        .DIV_10  (DIV_10)
    ) u_phase (
        .gmii_tx_clk   (gmii_tx_clk),
        .gmii_tx_rst_n (gmii_tx_rst_n),
        .i_speed       (r_speed),
        .i_speed_nx    (w_speed_nx),
        .i_restart     (w_spd_upd),
        .o_txc_d0      (w_txc0),
        .o_txc_d1      (w_txc1),
        .o_last        (w_last),
        .o_last_nx     (w_last_nx)
    );

    // Next state: speed change only between frames (en=0), except the very
    // first sample after reset, which always takes the requested speed.
    always_comb begin
        w_sample   = r_ready;
        w_spd_upd  = w_sample && (r_first || !gmii_tx_en);
        w_speed_nx = w_spd_upd ? norm_speed(speed) : r_speed;
        w_state_nx = r_state;
        if (w_speed_nx == SPEED_1000 || w_sample)
            w_state_nx = ST_LOW;
        else if (w_last)
            w_state_nx = (r_state == ST_LOW) ? ST_HIGH : ST_LOW;
        // ready is registered, so it is predicted from next-cycle state.
        w_ready_nx = (w_speed_nx == SPEED_1000) ||
                     ((w_state_nx == ST_HIGH) && w_last_nx);
    end

    // DDR pair for the byte held in r_data (already zeroed when en=0).
    always_comb begin
        w_nib = (r_state == ST_HIGH) ? r_data[7:4] : r_data[3:0];
        if (r_speed == SPEED_1000) begin
            w_txd0 = r_data[3:0];
            w_txd1 = r_data[7:4];
            w_tc0  = 1'b1;
            w_tc1  = 1'b0;
        end else begin
            w_txd0 = w_nib;
            w_txd1 = w_nib;
            w_tc0  = w_txc0;
            w_tc1  = w_txc1;
        end
        // TX_CTL carries en while TXC is high and en^er while TXC is low.
        w_ctl0 = w_tc0 ? r_en : (r_en ^ r_er);
        w_ctl1 = w_tc1 ? r_en : (r_en ^ r_er);
    end

    always_ff @(posedge gmii_tx_clk or negedge gmii_tx_rst_n) begin
        if (!gmii_tx_rst_n) r_state <= ST_LOW;
        else                r_state <= w_state_nx;
    end

    always_ff @(posedge gmii_tx_clk or negedge gmii_tx_rst_n) begin
        if (!gmii_tx_rst_n) begin
            r_speed <= SPEED_1000;
            r_first <= 1'b1;
            r_ready <= 1'b0;
            r_data  <= '0;
            r_en    <= 1'b0;
            r_er    <= 1'b0;
            r_txd0  <= '0;
            r_txd1  <= '0;
            r_ctl0  <= 1'b0;
            r_ctl1  <= 1'b0;
            r_tc0   <= 1'b0;
            r_tc1   <= 1'b0;
        end else begin
            r_speed <= w_speed_nx;
            r_ready <= w_ready_nx;
            r_txd0  <= w_txd0;
            r_txd1  <= w_txd1;
            r_ctl0  <= w_ctl0;
            r_ctl1  <= w_ctl1;
            r_tc0   <= w_tc0;
            r_tc1   <= w_tc1;
            if (w_sample) begin
                r_first <= 1'b0;
                r_data  <= gmii_tx_en ? gmii_tx_data : 8'h00;
                r_en    <= gmii_tx_en;
                r_er    <= gmii_tx_er;
            end
        end
    end

    assign gmii_tx_ready = r_ready;
    assign txd_d0        = r_txd0;
    assign txd_d1        = r_txd1;
    assign ctl_d0        = r_ctl0;
    assign ctl_d1        = r_ctl1;
    assign txc_d0        = r_tc0;
    assign txc_d1        = r_tc1;
    assign speed_active  = r_speed;

endmodule

// File: tb/tb_rgmii_tx_speed_adapter.sv
// Directed bench for rgmii_tx_speed_adapter with DIV_100=5, DIV_10=50.
// Output word compared each step: {ready, txd_d0, txd_d1, ctl_d0, ctl_d1, txc_d0, txc_d1}.
module tb_rgmii_tx_speed_adapter;

    logic       gmii_tx_clk = 1'b0;
    logic       gmii_tx_rst_n = 1'b0;
    logic [1:0] speed = 2'b10;
    logic [7:0] gmii_tx_data = 8'h00;
    logic       gmii_tx_en = 1'b0;
    logic       gmii_tx_er = 1'b0;
    logic       gmii_tx_ready;
    logic [3:0] txd_d0, txd_d1;
    logic       ctl_d0, ctl_d1, txc_d0, txc_d1;
    logic [1:0] speed_active;

    int n_chk  = 0;
    int n_pass = 0;

    rgmii_tx_speed_adapter #(.DIV_100(5), .DIV_10(50)) dut (
        .gmii_tx_clk   (gmii_tx_clk),
        .gmii_tx_rst_n (gmii_tx_rst_n),
        .speed         (speed),
        .gmii_tx_data  (gmii_tx_data),
        .gmii_tx_en    (gmii_tx_en),
        .gmii_tx_er    (gmii_tx_er),
        .gmii_tx_ready (gmii_tx_ready),
        .txd_d0        (txd_d0),
        .txd_d1        (txd_d1),
        .ctl_d0        (ctl_d0),
        .ctl_d1        (ctl_d1),
        .txc_d0        (txc_d0),
        .txc_d1        (txc_d1),
        .speed_active  (speed_active)
    );

    always #4 gmii_tx_clk = ~gmii_tx_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge gmii_tx_clk);
        #1;
    endtask

    function automatic logic [12:0] dut_word();
        return {gmii_tx_ready, txd_d0, txd_d1, ctl_d0, ctl_d1, txc_d0, txc_d1};
    endfunction

    function automatic logic [12:0] ew(input logic r, input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] c, input logic [1:0] t);
        return {r, a, b, c, t};
    endfunction

    // Counts cycles until ready is seen; the count itself is checked.
    task automatic wait_ready(input string tag, input int exp);
        int n = 0;
        while (!gmii_tx_ready && n < exp + 20) begin
            tick();
            n++;
        end
        chk(tag, n, exp);
    endtask

    task automatic drive(input logic [1:0] s, input logic [7:0] d, input logic e, input logic r);
        speed = s; gmii_tx_data = d; gmii_tx_en = e; gmii_tx_er = r;
    endtask

    initial begin
        logic [1:0] tbl5 [5];
        logic [3:0] nib;
        logic       t;
        tbl5 = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};

        // Reset state
        repeat (3) tick();
        chk("rst_word", dut_word(), 13'h0);
        chk("rst_speed", speed_active, 2'b10);

        // 1000M: A5, 3C, carrier extend, then gap requesting 100M
        gmii_tx_rst_n = 1'b1;
        wait_ready("rdy_after_rst", 1);
        drive(2'b10, 8'hA5, 1'b1, 1'b0); tick();
        drive(2'b10, 8'h3C, 1'b1, 1'b0); tick();
        chk("g_A5", dut_word(), ew(1'b1, 4'h5, 4'hA, 2'b11, 2'b10));
        drive(2'b10, 8'h77, 1'b0, 1'b1); tick();
        chk("g_3C", dut_word(), ew(1'b1, 4'hC, 4'h3, 2'b11, 2'b10));
        drive(2'b01, 8'h00, 1'b0, 1'b0); tick();
        chk("g_ext", dut_word(), ew(1'b0, 4'h0, 4'h0, 2'b01, 2'b10));
        chk("spd_to_100", speed_active, 2'b01);

        // 100M: byte 5A, then gap requesting 10M
        wait_ready("gap100", 9);
        drive(2'b01, 8'h5A, 1'b1, 1'b0); tick();
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            nib = (i < 5) ? 4'hA : 4'h5;
            chk($sformatf("w100_%0d", i), dut_word(),
                ew(i == 8, nib, nib, 2'b11, tbl5[i % 5]));
        end
        chk("spd_to_10", speed_active, 2'b00);

        // 10M: two FF bytes en=1 er=1; speed=01 requested mid-frame is deferred
        wait_ready("gap10", 99);
        drive(2'b00, 8'hFF, 1'b1, 1'b1); tick();
        drive(2'b01, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            tick();
            t = ((i % 50) < 25);
            chk($sformatf("w10_%0d", i), dut_word(),
                ew(i == 98 || i == 198, 4'hF, 4'hF, {t, t}, {t, t}));
            if (i == 99) begin
                chk("spd_deferred", speed_active, 2'b00);
                drive(2'b01, 8'h00, 1'b0, 1'b0);
            end
        end
        chk("spd_gap_100", speed_active, 2'b01);
        tick();
        chk("ph_restart", dut_word(), ew(1'b0, 4'h0, 4'h0, 2'b00, 2'b11));

        // Back to 10M, reset asserted while in the HIGH nibble
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        wait_ready("gap100b", 8);
        tick();
        drive(2'b00, 8'hFF, 1'b1, 1'b0);
        wait_ready("gap10b", 99);
        tick();
        repeat (60) tick();
        chk("high_pre_rst", dut_word(), ew(1'b0, 4'hF, 4'hF, 2'b11, 2'b11));
        #1 gmii_tx_rst_n = 1'b0;
        #1;
        chk("async_rst_word", dut_word(), 13'h0);
        chk("async_rst_spd", speed_active, 2'b10);

        // Release: first sample latches speed even with en=1
        drive(2'b01, 8'h12, 1'b1, 1'b0);
        repeat (2) tick();
        gmii_tx_rst_n = 1'b1;
        wait_ready("rdy_after_rst2", 1);
        tick();
        chk("first_latch", speed_active, 2'b01);
        drive(2'b01, 8'h00, 1'b0, 1'b0);
        tick();
        chk("post_rst_ph0", dut_word(), ew(1'b0, 4'h2, 4'h2, 2'b11, 2'b11));
        tick();
        chk("post_rst_ph1", dut_word(), ew(1'b0, 4'h2, 4'h2, 2'b11, 2'b11));
        tick();
        chk("post_rst_ph2", dut_word(), ew(1'b0, 4'h2, 4'h2, 2'b11, 2'b10));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_speed_adapter.md
RGMII_TX_SPEED_ADAPTER -- requirements
Module: rgmii_tx_speed_adapter

Interface
REQ-001 SHALL have parameter DIV_100, default 5: gmii_tx_clk cycles per RGMII TXC period at 100 Mb/s; any integer >= 2.
REQ-002 SHALL have parameter DIV_10, default 50: gmii_tx_clk cycles per TXC period at 10 Mb/s; any integer > DIV_100.
REQ-003 SHALL use a single clock and an asynchronous, active-low reset; no other clock or reset.
REQ-004 gmii_tx_clk  in  1  125 MHz clock, all logic on rising edge.
REQ-005 gmii_tx_rst_n  in  1  asynchronous reset, active low.
REQ-006 speed  in  2  00=10M, 01=100M, 10=1000M, 11 treated as 1000M.
REQ-007 gmii_tx_data  in  8  byte to transmit.
REQ-008 gmii_tx_en  in  1  byte valid / frame active.
REQ-009 gmii_tx_er  in  1  transmit error for this byte.
REQ-010 gmii_tx_ready  out  1  data/en/er/speed sampled on rising edge where high.
REQ-011 txd_d0, txd_d1  out  4 each  rising/falling-edge nibble for ODDRX1F D0/D1.
REQ-012 ctl_d0, ctl_d1  out  1 each  TX_CTL for ODDRX1F D0/D1.
REQ-013 txc_d0, txc_d1  out  1 each  TXC pattern for ODDRX1F D0/D1.
REQ-014 speed_active  out  2  speed currently applied.

Function
REQ-015 Sample = rising edge with gmii_tx_ready=1; data/en/er captured into a byte register, all outputs registered, 1-cycle latency from sample to first DDR pair.
REQ-016 1000M: gmii_tx_ready=1 every cycle; per cycle txd_d0=data[3:0], txd_d1=data[7:4], ctl_d0=en, ctl_d1=en^er, txc_d0=1, txc_d1=0.
REQ-017 10/100M: DIV = DIV_10 or DIV_100; phase counter ph counts 0..DIV-1, wraps to 0; runs continuously out of reset, byte or not.
REQ-018 10/100M: txc_d0 = (2*ph < DIV), txc_d1 = (2*ph+1 < DIV); DIV=5 gives d0/d1 pairs 11,11,10,00,00 (50% duty at half-cycle resolution).
REQ-019 10/100M: state machine LOW (txd_d0=txd_d1=data[3:0]) for one full TXC period, then HIGH (data[7:4]) for one full period, then LOW of next byte.
REQ-020 10/100M: ctl per half-cycle = en while that half's TXC bit is 1, en^er while 0; same for LOW and HIGH nibbles.
REQ-021 10/100M: gmii_tx_ready=1 only in cycle state=HIGH and ph=DIV-1, i.e. once per 2*DIV cycles.
REQ-022 Sampled en=0: txd=0, ctl=0 for that slot; TXC keeps toggling.
REQ-023 speed SHALL be latched into speed_active only on a sample with en=0; change with en=1 deferred to first en=0 sample; new speed applies from next slot, ph reset to 0, state LOW.
REQ-024 en=1 with er=1 SHALL be transmitted, not dropped; en=0 with er=1 yields ctl=0/1 half pattern (carrier extend) in 1000M, and ctl_d0=0, ctl_d1=1 analogue in 10/100M.
REQ-025 No data loss: every sampled byte SHALL appear on outputs exactly once, in order.

Reset
REQ-026 While gmii_tx_rst_n=0: all outputs 0, speed_active=10, ph=0, state LOW, byte register 0.
REQ-027 First sample after deassertion SHALL latch speed regardless of en; reset mid-frame aborts the frame immediately (outputs 0 same edge as assertion).

Structure
REQ-028 Shared package rgmii_pkg SHALL hold speed encodings (SPEED_10/100/1000) and the LOW/HIGH state enum.
REQ-029 One sub-module rgmii_txc_phase (ph counter, DIV select, txc_d0/d1, last-cycle flag); rest in top.

Verification
REQ-030 1000M, bytes 0xA5,0x3C with en=1 -> txd_d0/d1 = 5/A then C/3, ctl 1/1, txc 1/0, ready constantly 1.
REQ-031 100M DIV=5, byte 0x5A en=1 -> 5 cycles txd=A, 5 cycles txd=5, txc pairs 11,11,10,00,00 each period, ready high 1 cycle per 10.
REQ-032 10M, en=1 er=1, byte 0xFF -> 100 cycles txd=F, ctl=1 on TXC-high halves, 0 on TXC-low halves.
REQ-033 speed 10->01 asserted mid-frame -> speed_active stays 10 until first en=0 sample, then 01 with ph=0.
REQ-034 Reset asserted in 10M HIGH state -> all outputs 0 asynchronously; after release first sample latches speed, txc restarts at ph=0.
REQ-035 Random frames, random speed at gaps, scoreboard -> byte order, count and nibble order match input exactly.
